pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 133 +++++++++++++
 tb/tb_pwm_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an external PWM input in clk cycles.
// Optional glitch filter enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             stuck_high,
  output logic             stuck_low
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, next_state;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise;
  logic [CNT_W-1:0] cnt, hcnt;
  logic do_load, do_report, do_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic [FILT_LEN-1:0] filt_hist;

  // s only moves once the whole history window agrees on the new level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_hist <= '0;
      s         <= 1'b0;
    end else begin
      filt_hist <= {filt_hist[FILT_LEN-2:0], sync[SYNC_STAGES-1]};
      if (&filt_hist)       s <= 1'b1;
      else if (~|filt_hist) s <= 1'b0;
    end
  end
`else
  assign s = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise   = s & ~s_d;
  assign locked = (state == MEASURE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A rise always wins over a timeout landing on the same cycle
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_report  = 1'b0;
    do_timeout = 1'b0;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            next_state = MEASURE;
            do_load    = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            do_load   = 1'b1;
            do_report = 1'b1;
          end else if (cnt == CNT_MAX) begin
            do_timeout = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      hcnt       <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= do_report;
      if (!en) begin
        cnt        <= '0;
        hcnt       <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (do_load) begin
        if (do_report) begin
          period_out <= cnt;
          high_out   <= hcnt;
        end
        cnt        <= CNT_ONE;
        hcnt       <= CNT_ONE;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (do_timeout) begin
        stuck_high <= s;
        stuck_low  <= ~s;
      end else if (state == MEASURE) begin
        // cnt stops at CNT_MAX via the timeout branch, so it never wraps
        cnt <= cnt + CNT_ONE;
        if (s) hcnt <= hcnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a cycle model of the driven waveform pushes
// expected measurements into a queue that a monitor pops on every meas_valid strobe.
module tb_pwm_capture;

  localparam int CNT_W    = 8;
  localparam int MAXC     = 255;
  localparam int FILT_LEN = 3;

  logic clk = 1'b0;
  logic rst_n, en, pwm_in;
  logic [CNT_W-1:0] period_out, high_out;
  logic meas_valid, locked, stuck_high, stuck_low;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  int last_p, last_h;

  logic m_prev, m_locked, mf;
  logic [FILT_LEN-1:0] fh;
  int c, h;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .locked(locked), .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev   = 1'b0;
    m_locked = 1'b0;
    mf       = 1'b0;
    fh       = '0;
    c        = 0;
    h        = 0;
  endtask

  // Measurement model on the driven waveform; the DUT sees the same sequence delayed
  task automatic model_step(input logic v);
    logic mv, r;
`ifdef PWM_GLITCH_FILTER_EN
    fh = {fh[FILT_LEN-2:0], v};
    if (&fh)       mf = 1'b1;
    else if (~|fh) mf = 1'b0;
    mv = mf;
`else
    mv = v;
`endif
    r = mv & ~m_prev;
    m_prev = mv;
    if (r) begin
      if (m_locked) begin
        exp_q.push_back({8'(c), 8'(h)});
        last_p = c;
        last_h = h;
      end
      m_locked = 1'b1;
      c = 1;
      h = 1;
    end else if (m_locked) begin
      if (c == MAXC) m_locked = 1'b0;
      else begin
        c++;
        if (mv) h++;
      end
    end
  endtask

  task automatic drive_cycle(input logic v);
    @(negedge clk);
    pwm_in = v;
    model_step(v);
  endtask

  task automatic drive_n(input logic v, input int n);
    for (int i = 0; i < n; i++) drive_cycle(v);
  endtask

  task automatic apply_stimulus(input int p, input int hi, input int periods);
    for (int k = 0; k < periods; k++) begin
      drive_n(1'b1, hi);
      drive_n(1'b0, p - hi);
    end
  endtask

  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (meas_valid) begin
        check("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("period_out", period_out, e[15:8]);
          check("high_out", high_out, e[7:0]);
        end
      end
    end
  end

  initial begin
    last_p = 0;
    last_h = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b0;
    model_reset();
    drive_n(1'b0, 3);
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_stuck_high", stuck_high, 0);
    check("rst_stuck_low", stuck_low, 0);
    rst_n = 1'b1;
    drive_n(1'b0, 4);

    $display("[TB] steady 16/8 then 10/3");
    apply_stimulus(16, 8, 6);
    check("locked_16_8", locked, 1);
    apply_stimulus(10, 3, 6);
    check("locked_10_3", locked, 1);

    $display("[TB] stuck high then resume");
    drive_n(1'b1, 270);
    check("sh_stuck_high", stuck_high, 1);
    check("sh_stuck_low", stuck_low, 0);
    check("sh_locked", locked, 0);
    drive_n(1'b0, 8);
    drive_n(1'b1, 8);
    drive_n(1'b0, 4);
    check("resume_stuck_high", stuck_high, 0);
    check("resume_locked", locked, 1);
    drive_n(1'b0, 4);
    apply_stimulus(16, 8, 3);

    $display("[TB] stuck low");
    drive_n(1'b0, 300);
    check("sl_stuck_low", stuck_low, 1);
    check("sl_stuck_high", stuck_high, 0);
    check("sl_period_hold", period_out, last_p);
    check("sl_high_hold", high_out, last_h);

    $display("[TB] reset mid-period");
    apply_stimulus(16, 8, 3);
    drive_n(1'b1, 8);
    drive_n(1'b0, 4);
    rst_n = 1'b0;
    drive_cycle(1'b0);
    model_reset();
    check("mid_rst_period", period_out, 0);
    check("mid_rst_high", high_out, 0);
    check("mid_rst_locked", locked, 0);
    rst_n = 1'b1;
    drive_n(1'b0, 4);
    apply_stimulus(16, 8, 4);

    $display("[TB] enable drop mid-period");
    drive_n(1'b1, 8);
    drive_n(1'b0, 4);
    en = 1'b0;
    m_locked = 1'b0;
    c = 0;
    h = 0;
    drive_n(1'b0, 3);
    check("en_off_locked", locked, 0);
    en = 1'b1;
    drive_n(1'b0, 4);
    apply_stimulus(16, 8, 4);

    $display("[TB] glitch in low phase");
    apply_stimulus(16, 8, 2);
    drive_n(1'b1, 8);
    drive_n(1'b0, 4);
    drive_n(1'b1, 1);
    drive_n(1'b0, 3);
    apply_stimulus(16, 8, 3);

    drive_n(1'b0, 20);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
